// File: rtl/mem_march_if.sv
// Pin-level bus between the march sequencer and the 64x8 latch memory.
// The master drives address, write strobe and write data; the slave returns read data.
interface mem_march_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wr_en,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_march_driver.sv
// Two-pass write/readback self-check sequencer for the latch memory.
// Reports pass/fail, the mismatch count and the first failing location.
module mem_march_driver #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  mem_march_if.master       bus,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_pass
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CW-1:0] ISSUE_N = CW'(DEPTH);
  localparam logic [CW-1:0] RD_END  = CW'(DEPTH + READ_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, W0, R0, W1, R1, DONE
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              ph, ph_d;
  logic              clr, pass, wr_st, rd_st, issue, mism;
  logic [DATA_W-1:0] seed_q;

  logic              pv [READ_LAT];
  logic [DATA_W-1:0] pe [READ_LAT];
  logic [ADDR_W-1:0] pa [READ_LAT];
  logic              pp [READ_LAT];

  function automatic logic [DATA_W-1:0] pat(
    input logic [DATA_W-1:0] s,
    input logic [ADDR_W-1:0] a,
    input logic              p
  );
    logic [DATA_W-1:0] v;
    v = DATA_W'(a) ^ s;
    return p ? ~v : v;
  endfunction

  assign pass  = (state == W1) || (state == R1);
  assign wr_st = (state == W0) || (state == W1);
  assign rd_st = (state == R0) || (state == R1);
  assign issue = rd_st && (cnt < ISSUE_N);
  assign mism  = pv[READ_LAT-1] &&
                 (bus.mem_rdata != pe[READ_LAT-1]);

  always_comb begin
    state_d = state;
    addr_d  = addr;
    cnt_d   = cnt;
    ph_d    = ph;
    clr     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = W0;
          addr_d  = '0;
          ph_d    = 1'b0;
          clr     = 1'b1;
        end
      end
      W0, W1: begin
        ph_d = ~ph;
        if (ph) begin
          if (addr == LAST) begin
            state_d = (state == W0) ? R0 : R1;
            addr_d  = '0;
            cnt_d   = '0;
          end else begin
            addr_d = addr + 1'b1;
          end
        end
      end
      R0, R1: begin
        cnt_d = cnt + 1'b1;
        ph_d  = 1'b0;
        // Address stops at the last word and is held through the drain
        if (cnt < ISSUE_N - 1'b1) addr_d = addr + 1'b1;
        if (cnt == RD_END) begin
          state_d = (state == R0) ? W1 : DONE;
          addr_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      cnt    <= '0;
      ph     <= 1'b0;
      seed_q <= '0;
    end else begin
      state <= state_d;
      addr  <= addr_d;
      cnt   <= cnt_d;
      ph    <= ph_d;
      if (clr) seed_q <= seed;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pv[i] <= 1'b0;
        pe[i] <= '0;
        pa[i] <= '0;
        pp[i] <= 1'b0;
      end
    end else begin
      pv[0] <= issue;
      pe[0] <= pat(seed_q, addr, pass);
      pa[0] <= addr;
      pp[0] <= pass;
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pa[i] <= pa[i-1];
        pp[i] <= pp[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count      <= '0;
      fail           <= 1'b0;
      first_err_addr <= '0;
      first_err_pass <= 1'b0;
    end else if (clr) begin
      err_count      <= '0;
      fail           <= 1'b0;
      first_err_addr <= '0;
      first_err_pass <= 1'b0;
    end else if (mism) begin
      err_count <= err_count + 1'b1;
      fail      <= 1'b1;
      if (!fail) begin
        first_err_addr <= pa[READ_LAT-1];
        first_err_pass <= pp[READ_LAT-1];
      end
    end
  end

  assign busy          = wr_st || rd_st;
  assign done          = (state == DONE);
  assign bus.mem_addr  = addr;
  assign bus.mem_wr_en = wr_st && !ph;
  assign bus.mem_wdata = wr_st ? pat(seed_q, addr, pass) : '0;

endmodule
